// File: rtl/melody_beat_sequencer.sv
// Tempo generator and beat-index sequencer for the melody player ROMs.
// A prescaler divides the system clock into beats. The beat index steps
// from 0 to SONG_LEN-1 under play/pause/stop control, with optional looping.
// All outputs come straight from registers.
module melody_beat_sequencer #(
    parameter int unsigned BEAT_DIV = 6250000, // cycles per beat at tempo_sel=0, >= 2
    parameter int unsigned SONG_LEN = 168,     // beat indices in the song, 1..256
    parameter int unsigned DIV_W    = 32       // must hold (BEAT_DIV<<3)-1
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       play,
    input  logic       pause,
    input  logic       stop,
    input  logic       loop_en,
    input  logic [1:0] tempo_sel,
    output logic [7:0] beats,
    output logic       playing,
    output logic       beat_tick,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_FINISHED = 2'd3
    } state_e;

    localparam logic [DIV_W-1:0] BEAT_DIV_W = DIV_W'(BEAT_DIV);
    localparam logic [7:0]       LAST_BEAT  = 8'(SONG_LEN - 1);

    // Registered state and its next-state values.
    state_e           state_q,   state_d;
    logic [7:0]       beats_q,   beats_d;
    logic [DIV_W-1:0] presc_q,   presc_d;
    logic             tick_q,    tick_d;
    logic             done_q,    done_d;
    logic             playing_q, playing_d;

    // Previous level of the command inputs, for rising-edge detection.
    logic             play_q;
    logic             pause_q;

    logic             play_rise;
    logic             pause_rise;
    logic [DIV_W-1:0] limit_m1;
    logic             beat_end;

    assign play_rise  = play  & ~play_q;
    assign pause_rise = pause & ~pause_q;

    // Beat length follows tempo_sel live. Using >= rather than == means a
    // tempo increase that leaves the prescaler past the new limit ends the
    // current beat on the next cycle instead of counting all the way around.
    assign limit_m1 = (BEAT_DIV_W << tempo_sel) - DIV_W'(1);
    assign beat_end = (presc_q >= limit_m1);

    // Edge-detect history follows the inputs every cycle, whatever the state.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the clock edge, independent of block order.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            play_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            play_q  <= play;
            pause_q <= pause;
        end
    end

    // State, counters and output pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            beats_q   <= 8'd0;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            playing_q <= playing_d;
        end
    end

    // Next-state logic. Command priority is stop, then play edge, then pause
    // edge. Beat counting happens only in PLAYING with no command pending.
    // The final beat_tick and done are raised by the PLAYING branch on the same
    // edge that moves the state to FINISHED. No other state ever raises them.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        beats_d = beats_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            beats_d = 8'd0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play_rise) begin
                        state_d = ST_PLAYING;
                        beats_d = 8'd0;
                        presc_d = '0;
                    end
                end

                ST_PLAYING: begin
                    if (play_rise) begin
                        // Restart the song from the top.
                        beats_d = 8'd0;
                        presc_d = '0;
                    end else if (pause_rise) begin
                        // Freeze with prescaler and beat index held.
                        state_d = ST_PAUSED;
                    end else if (beat_end) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (beats_q < LAST_BEAT) begin
                            beats_d = beats_q + 8'd1;
                        end else if (loop_en) begin
                            beats_d = 8'd0;
                        end else begin
                            // Song complete. Index stays on the last beat.
                            done_d  = 1'b1;
                            state_d = ST_FINISHED;
                        end
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end

                ST_PAUSED: begin
                    // Either edge resumes from the held position.
                    if (play_rise || pause_rise) begin
                        state_d = ST_PLAYING;
                    end
                end

                ST_FINISHED: begin
                    if (play_rise) begin
                        state_d = ST_PLAYING;
                        beats_d = 8'd0;
                        presc_d = '0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    beats_d = 8'd0;
                    presc_d = '0;
                end
            endcase
        end

        playing_d = (state_d == ST_PLAYING);
    end

    assign beats     = beats_q;
    assign playing   = playing_q;
    assign beat_tick = tick_q;
    assign done      = done_q;

endmodule
